// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame shape, default baud divisor.
// UART_TX_PARITY_EN adds the PARITY state for 8E1 frames.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int CLKS_PER_BIT_DEF = 1085;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte request and status bundle between fabric logic and uart_tx.
// master = requester, slave = transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_d;
  logic                 tx_rdy;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_full;
  logic                 tx_done;
  logic                 tx_drop;

  modport master (
    output tx_d, tx_rdy,
    input  tx, tx_busy, tx_full,
    input  tx_done, tx_drop
  );

  modport slave (
    input  tx_d, tx_rdy,
    output tx, tx_busy, tx_full,
    output tx_done, tx_drop
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS-1, pulses tick at terminal count.
// clr holds the count at zero; shared with the receive path.
module uart_baud_tick #(
    parameter int CLKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLKS > 1) ? $clog2(CLKS) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS - 1);

    logic [W-1:0] cnt;

    assign tick = !clr && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter with a one-byte holding buffer.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit after data).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic     clk_125MHz,
    input  logic     rst,
    uart_tx_if.slave bus
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    uart_state_t          state, state_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic [DATA_BITS-1:0] buf_q, buf_n;
    logic                 full, full_n;
    logic                 drop, drop_n;
    logic                 tx_q, tx_n;
    logic                 clr, tick, done, drain;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_n;
`endif

    uart_baud_tick #(.CLKS(CLKS_PER_BIT)) u_baud (
        .clk  (clk_125MHz),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    assign drain = (state == ST_STOP) && tick && full;

    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        sh_n    = sh;
        buf_n   = buf_q;
        full_n  = full;
        drop_n  = 1'b0;
        clr     = 1'b0;
        done    = 1'b0;
        tx_n    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        unique case (state)
            ST_IDLE: begin
                clr = 1'b1;
                if (bus.tx_rdy) begin
                    sh_n    = bus.tx_d;
                    state_n = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^bus.tx_d;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_n   = '0;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    sh_n  = sh >> 1;
                    bit_n = bit_cnt + BW'(1);
                    if (bit_cnt == BIT_LAST)
`ifdef UART_TX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) state_n = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    done = 1'b1;
                    if (full) begin
                        sh_n    = buf_q;
                        full_n  = 1'b0;
                        state_n = ST_START;
`ifdef UART_TX_PARITY_EN
                        par_n   = ^buf_q;
`endif
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A buffer being drained this cycle can take the new byte
        if (bus.tx_rdy && state != ST_IDLE) begin
            if (!full || drain) begin
                buf_n  = bus.tx_d;
                full_n = 1'b1;
            end else begin
                drop_n = 1'b1;
            end
        end

        unique case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = sh_n[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_n = par_n;
`endif
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_125MHz or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            sh      <= '0;
            buf_q   <= '0;
            full    <= 1'b0;
            drop    <= 1'b0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            bit_cnt <= bit_n;
            sh      <= sh_n;
            buf_q   <= buf_n;
            full    <= full_n;
            drop    <= drop_n;
            tx_q    <= tx_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_full = full;
    assign bus.tx_drop = drop;
    assign bus.tx_done = done;
    assign bus.tx_busy = (state != ST_IDLE) | full;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4.
// Frames are given as hand-written bit vectors, bit 0 sent first.
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(4)) dut (
        .clk_125MHz (clk),
        .rst        (rst),
        .bus        (bus)
    );

    always #4 clk = ~clk;

    // Frame bits in send order (bit 0 = start bit)
    localparam logic [9:0]  F41 = 10'b1010000010;
    localparam logic [9:0]  F42 = 10'b1010000100;
    localparam logic [10:0] F61P = 11'b11011000010;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic idle_checks(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, " tx"}, {7'd0, bus.tx}, 8'd1);
            check({tag, " flags"},
                  {4'd0, bus.tx_busy, bus.tx_full,
                   bus.tx_done, bus.tx_drop}, 8'd0);
            step();
        end
    endtask

    task automatic strobe(input logic [7:0] d);
        bus.tx_d   = d;
        bus.tx_rdy = 1'b1;
        step();
        bus.tx_rdy = 1'b0;
    endtask

    // Called right after the accepting edge (cycle j=0 of the frame).
    task automatic run_stream(input string tag,
                              input logic [21:0] s,
                              input int nb, input int fb,
                              input int ja, input logic [7:0] da,
                              input int jb, input logic [7:0] db,
                              input int flo, input int fhi,
                              input int dj);
        int n;
        n = nb * 4;
        for (int j = 0; j < n; j++) begin
            bus.tx_rdy = (j == ja) || (j == jb);
            bus.tx_d   = (j == jb) ? db : da;
            check({tag, " tx"}, {7'd0, bus.tx}, {7'd0, s[j/4]});
            check({tag, " busy"}, {7'd0, bus.tx_busy}, 8'd1);
            check({tag, " done"}, {7'd0, bus.tx_done},
                  {7'd0, (j % (fb*4)) == fb*4 - 1});
            check({tag, " full"}, {7'd0, bus.tx_full},
                  {7'd0, (j >= flo) && (j <= fhi)});
            check({tag, " drop"}, {7'd0, bus.tx_drop},
                  {7'd0, j == dj});
            step();
        end
        bus.tx_rdy = 1'b0;
        check({tag, " busy end"}, {7'd0, bus.tx_busy}, 8'd0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.tx_rdy = 1'b0;
        bus.tx_d   = 8'h00;
        step();
        step();
        check("rst tx", {7'd0, bus.tx}, 8'd1);
        check("rst flags",
              {4'd0, bus.tx_busy, bus.tx_full,
               bus.tx_done, bus.tx_drop}, 8'd0);
        rst = 1'b0;
        idle_checks("idle", 100);

`ifdef UART_TX_PARITY_EN
        strobe(8'h61);
        run_stream("par61", {11'd0, F61P}, 11, 11,
                   -1, 8'h00, -1, 8'h00, -1, -1, -1);
        idle_checks("post par", 8);
`else
        strobe(8'h41);
        run_stream("single", {12'd0, F41}, 10, 10,
                   -1, 8'h00, -1, 8'h00, -1, -1, -1);
        idle_checks("post single", 8);

        strobe(8'h41);
        run_stream("b2b", {2'd0, F42, F41}, 20, 10,
                   -1, 8'h00, 1, 8'h42, 2, 39, -1);
        idle_checks("post b2b", 8);

        strobe(8'h41);
        run_stream("three", {2'd0, F42, F41}, 20, 10,
                   0, 8'h42, 1, 8'h43, 1, 39, 2);
        idle_checks("post three", 40);

        strobe(8'h41);
        bus.tx_d   = 8'h43;
        bus.tx_rdy = 1'b1;
        step();
        bus.tx_rdy = 1'b0;
        for (int i = 0; i < 13; i++) step();
        check("pre rst full", {7'd0, bus.tx_full}, 8'd1);
        rst = 1'b1;
        #1;
        check("mid rst tx", {7'd0, bus.tx}, 8'd1);
        check("mid rst flags",
              {4'd0, bus.tx_busy, bus.tx_full,
               bus.tx_done, bus.tx_drop}, 8'd0);
        step();
        rst = 1'b0;
        idle_checks("after rst", 10);
        strobe(8'h42);
        run_stream("clean", {12'd0, F42}, 10, 10,
                   -1, 8'h00, -1, 8'h00, -1, -1, -1);
        idle_checks("buf lost", 40);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
